// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder fronting a byte RAM: 8-bit opcode, 16-bit address, then
// streaming read or write data with address auto-increment. Backdoor read port for observation.
module spi_ram_responder #(
    parameter int         ADDR_BITS = 8,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 cs,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 busy,
    input  logic [ADDR_BITS-1:0] bd_addr,
    output logic [7:0]           bd_data
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, IGNORE
    } state_t;

    state_t               state;
    logic [1:0]           sclk_s;
    logic [1:0]           cs_s;
    logic [1:0]           mosi_s;
    logic                 sclk_q;
    logic                 cs_q;
    logic [2:0]           bit_cnt;
    logic [6:0]           shreg_in;
    logic [7:0]           shreg_out;
    logic [ADDR_BITS-1:0] addr;
    logic                 is_read;
    logic [7:0]           mem [2**ADDR_BITS];

    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 cs_sync;
    logic                 cs_fall;
    logic                 mosi_bit;
    logic [7:0]           byte_in;
    logic                 byte_done;
    logic [ADDR_BITS-1:0] addr_next;
    logic [ADDR_BITS-1:0] addr_inc;
    logic                 wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= 2'b00;
            cs_s   <= 2'b11;
            mosi_s <= 2'b00;
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[0], sclk};
            cs_s   <= {cs_s[0], cs};
            mosi_s <= {mosi_s[0], mosi};
            sclk_q <= sclk_s[1];
            cs_q   <= cs_s[1];
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_q;
    assign sclk_fall = ~sclk_s[1] & sclk_q;
    assign cs_sync   = cs_s[1];
    assign cs_fall   = cs_q & ~cs_sync;
    assign mosi_bit  = mosi_s[1];
    assign byte_in   = {shreg_in, mosi_bit};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    // Both address bytes shift through addr, so only the low ADDR_BITS survive (aliasing).
    assign addr_next = {addr[ADDR_BITS-2:0], mosi_bit};
    assign addr_inc  = addr + ADDR_BITS'(1);
    assign wr_en     = (state == WR_DATA) && byte_done && !cs_sync;

    assign miso_oe = ~cs_sync;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg_in  <= 7'd0;
            shreg_out <= 8'd0;
            addr      <= '0;
            is_read   <= 1'b0;
            miso      <= 1'b0;
        end else if (cs_sync) begin
            // Deselect wins over any coincident sclk rise: partial bytes are dropped.
            state   <= IDLE;
            bit_cnt <= 3'd0;
            miso    <= 1'b0;
        end else begin
            if (sclk_rise) begin
                shreg_in <= byte_in[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (state != RD_DATA) begin
                miso <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= CMD;
                        bit_cnt <= 3'd0;
                    end
                end
                CMD: begin
                    if (byte_done) begin
                        if (byte_in == CMD_READ) begin
                            is_read <= 1'b1;
                            state   <= ADDR_HI;
                        end else if (byte_in == CMD_WRITE) begin
                            is_read <= 1'b0;
                            state   <= ADDR_HI;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                end
                ADDR_HI: begin
                    if (sclk_rise) addr <= addr_next;
                    if (byte_done) state <= ADDR_LO;
                end
                ADDR_LO: begin
                    if (sclk_rise) addr <= addr_next;
                    if (byte_done) begin
                        if (is_read) begin
                            shreg_out <= mem[addr_next];
                            state     <= RD_DATA;
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (sclk_fall) begin
                        miso      <= shreg_out[7];
                        shreg_out <= {shreg_out[6:0], 1'b0};
                    end
                    // Prefetch the next byte on the last rise so the next fall starts it.
                    if (byte_done) begin
                        addr      <= addr_inc;
                        shreg_out <= mem[addr_inc];
                    end
                end
                WR_DATA: begin
                    if (byte_done) addr <= addr_inc;
                end
                IGNORE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= byte_in;
        end
        bd_data <= (wr_en && (addr == bd_addr)) ? byte_in : mem[bd_addr];
    end

endmodule
